// File: rtl/addrc_pkg.sv
// Shared constants for the addRC (iota) sequencing controller.
// Holds round-count parameters and the controller state encodings.
package addrc_pkg;
  localparam int NUM_ROUNDS = 24;
  localparam int ROUND_W    = 5;
  localparam int SLICES     = 64;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_XOR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/addrc_round_counter.sv
// Wrapping modulo-N round index with synchronous clear (priority) and increment.
module addrc_round_counter
  import addrc_pkg::*;
#(
  parameter int N = NUM_ROUNDS,
  parameter int W = ROUND_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_value,
  output logic         o_term
);
  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_value <= '0;
    else if (i_clr) r_value <= '0;
    else if (i_inc) r_value <= o_term ? '0 : r_value + 1'b1;
  end

  assign o_value = r_value;
  assign o_term  = (r_value == W'(N - 1));
endmodule

// File: rtl/addrc_controller.sv
// Sequencing FSM for the addRC datapath: one CLR, 64 LOAD/XOR pairs, DONE per round.
// Strobes are Moore-decoded; last_round also looks at the round index.
module addrc_controller #(
  parameter int NUM_ROUNDS = addrc_pkg::NUM_ROUNDS,
  parameter int ROUND_W    = addrc_pkg::ROUND_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               round_clr,
  input  logic               abort,
  input  logic               cnt_co_64,
  output logic               ready,
  output logic               busy,
  output logic               cnt_rst_64,
  output logic               inreg_en,
  output logic               xor_en,
  output logic               cnt_en_64,
  output logic [ROUND_W-1:0] cnt24_value,
  output logic               done,
  output logic               last_round
);
  import addrc_pkg::S_IDLE;
  import addrc_pkg::S_CLR;
  import addrc_pkg::S_LOAD;
  import addrc_pkg::S_XOR;
  import addrc_pkg::S_DONE;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_round_clr;
  logic       w_round_inc;
  logic       w_round_term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // abort wins over every other transition once a sweep is underway
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_CLR : S_IDLE;
      S_CLR:   w_next = abort ? S_IDLE : S_LOAD;
      S_LOAD:  w_next = abort ? S_IDLE : S_XOR;
      S_XOR: begin
        if (abort)          w_next = S_IDLE;
        else if (cnt_co_64) w_next = S_DONE;
        else                w_next = S_LOAD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // an abort landing on DONE still suppresses the round advance
  assign w_round_clr = (r_state == S_IDLE) && round_clr;
  assign w_round_inc = (r_state == S_DONE) && !abort;

  addrc_round_counter #(
    .N (NUM_ROUNDS),
    .W (ROUND_W)
  ) u_round (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_round_clr),
    .i_inc   (w_round_inc),
    .o_value (cnt24_value),
    .o_term  (w_round_term)
  );

  assign ready      = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign cnt_rst_64 = (r_state == S_CLR);
  assign inreg_en   = (r_state == S_LOAD);
  assign xor_en     = (r_state == S_XOR);
  assign cnt_en_64  = (r_state == S_XOR);
  assign done       = (r_state == S_DONE);
  assign last_round = (r_state == S_DONE) && w_round_term;
endmodule

// File: tb/tb_addrc_controller.sv
// Bench for addrc_controller: a sweep-position model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_addrc_controller;
  localparam int NR       = 24;
  localparam int SL       = 64;
  localparam int DONE_POS = 2 + 2 * SL;

  logic       clk = 1'b0, rst = 1'b0;
  logic       start = 1'b0, round_clr = 1'b0, abort = 1'b0;
  logic       cnt_co_64;
  logic       ready, busy, cnt_rst_64, inreg_en, xor_en, cnt_en_64, done, last_round;
  logic [4:0] cnt24_value;

  int n_chk = 0, n_err = 0;
  int n_inreg = 0, n_xor = 0, n_done = 0, n_last = 0;
  int m_pos, m_round;
  int lat;

  always #5 clk = ~clk;

  addrc_controller dut (
    .clk(clk), .rst(rst), .start(start), .round_clr(round_clr), .abort(abort),
    .cnt_co_64(cnt_co_64), .ready(ready), .busy(busy), .cnt_rst_64(cnt_rst_64),
    .inreg_en(inreg_en), .xor_en(xor_en), .cnt_en_64(cnt_en_64),
    .cnt24_value(cnt24_value), .done(done), .last_round(last_round)
  );

  // datapath slice counter stand-in
  logic [5:0] slice;
  always @(posedge clk or negedge rst) begin
    if (!rst)            slice <= 6'd0;
    else if (cnt_rst_64) slice <= 6'd0;
    else if (cnt_en_64)  slice <= slice + 6'd1;
  end
  assign cnt_co_64 = (slice == 6'd63);

  // model: m_pos = cycle offset inside the current sweep (0 = idle)
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pos <= 0; m_round <= 0;
    end else if (m_pos == 0) begin
      if (round_clr) m_round <= 0;
      if (start)     m_pos   <= 1;
    end else if (abort) begin
      m_pos <= 0;
    end else if (m_pos == DONE_POS) begin
      m_pos <= 0; m_round <= (m_round + 1) % NR;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic logic [12:0] model_out(input int pos, input int rnd);
    logic d, ld, xr;
    d  = (pos == DONE_POS);
    ld = (pos >= 2) && (pos < DONE_POS) && (pos % 2 == 0);
    xr = (pos >= 3) && (pos < DONE_POS) && (pos % 2 == 1);
    return {pos == 0, pos != 0, pos == 1, ld, xr, xr, d, d && (rnd == NR - 1), 5'(rnd)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("cycle_outputs",
          {19'd0, ready, busy, cnt_rst_64, inreg_en, xor_en, cnt_en_64, done, last_round, cnt24_value},
          {19'd0, model_out(m_pos, m_round)});
      n_inreg += int'(inreg_en);
      n_xor   += int'(xor_en);
      n_done  += int'(done);
      n_last  += int'(last_round);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input bit noise, output int l);
    l = 1;
    while (done !== 1'b1 && l < 300) begin
      if (noise) begin
        start     = 1'($urandom % 2);
        round_clr = 1'($urandom % 2);
      end
      tick();
      l++;
    end
    start = 1'b0; round_clr = 1'b0;
    tick();
  endtask

  task automatic run_sweep(input bit noise, output int l);
    n_inreg = 0; n_xor = 0; n_done = 0; n_last = 0;
    start = 1'b1;
    tick();
    start = 1'b0; round_clr = 1'b0;
    wait_done(noise, l);
    chk("sweep_latency", l, DONE_POS);
    chk("inreg_pulses", n_inreg, SL);
    chk("xor_pulses", n_xor, SL);
    chk("done_pulses", n_done, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals", {ready, busy, cnt_rst_64, inreg_en, xor_en, cnt_en_64, done, last_round, cnt24_value},
        13'b1000_0000_00000);
    rst = 1'b1;
    tick();
    chk("post_reset_ready", ready, 1);

    // single sweep, then the rest of a full 24-round permutation
    chk("round_start0", cnt24_value, 0);
    run_sweep(1'b0, lat);
    chk("round_after1", cnt24_value, 1);
    chk("no_last_round1", n_last, 0);
    for (int i = 1; i < NR; i++) begin
      chk("round_step", cnt24_value, i);
      run_sweep(1'b0, lat);
      chk("last_round_cnt", n_last, (i == NR - 1) ? 1 : 0);
    end
    chk("round_wrap", cnt24_value, 0);

    for (int i = 0; i < 5; i++) run_sweep(1'b0, lat);
    chk("round_at5", cnt24_value, 5);

    // abort in the 10th XOR cycle (offset 21 from the start edge)
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("tenth_xor", xor_en, 1);
    abort = 1'b1; n_done = 0;
    tick();
    abort = 1'b0;
    chk("abort_idle", ready, 1);
    chk("abort_round", cnt24_value, 5);
    repeat (3) tick();
    chk("abort_no_done", n_done, 0);
    run_sweep(1'b0, lat);
    chk("restart_round", cnt24_value, 6);

    // start/round_clr toggling while busy must not disturb the sweep
    run_sweep(1'b1, lat);
    chk("noise_round", cnt24_value, 7);

    // round_clr together with start
    round_clr = 1'b1; start = 1'b1;
    tick();
    round_clr = 1'b0; start = 1'b0;
    chk("clr_sweep_round", cnt24_value, 0);
    wait_done(1'b0, lat);
    chk("clr_latency", lat, DONE_POS);
    chk("clr_end_round", cnt24_value, 1);

    // reset mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    rst = 1'b0;
    #2;
    chk("midreset_vals", {ready, busy, cnt_rst_64, inreg_en, xor_en, cnt_en_64, done, last_round, cnt24_value},
        13'b1000_0000_00000);
    tick();
    rst = 1'b1;
    tick();
    chk("midreset_ready", ready, 1);

    // randomized soak against the model
    repeat (4000) begin
      start     = ($urandom % 6 == 0);
      round_clr = ($urandom % 10 == 0);
      abort     = ($urandom % 120 == 0);
      tick();
    end
    start = 1'b0; round_clr = 1'b0; abort = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 300) begin tick(); lat++; end
    chk("final_idle", ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/addrc_controller.md
Name: addrc_controller

Overview:
- Sequencing FSM for the addRC (iota, round-constant XOR) datapath.
- Drives the 64-slice sweep counter's reset and enable, the input-register load and the XOR strobe.
- Owns the 24-round index presented to the datapath as cnt24_value.
- Gives the top-level permutation scheduler a start/ready/done handshake, one sweep per round.

Parameters:
- NUM_ROUNDS, 24, rounds per permutation; the round index wraps after NUM_ROUNDS-1.
- ROUND_W, 5, width of the round index.
- SLICES, 64, slices per sweep. Documentation only; sweep end comes from cnt_co_64.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  sweep request; accepted only while ready=1.
- round_clr  in  1  forces round index to 0; honoured only in IDLE.
- abort  in  1  synchronous abort of an in-progress sweep.
- cnt_co_64  in  1  slice-counter carry out; high while the datapath slice count = 63.
- ready  out  1  high in IDLE.
- busy  out  1  high in any state other than IDLE.
- cnt_rst_64  out  1  synchronous clear of the slice counter.
- inreg_en  out  1  loads the current slice into the datapath register.
- xor_en  out  1  applies the round constant to the current slice.
- cnt_en_64  out  1  advances the slice counter.
- cnt24_value  out  ROUND_W  current round index into the round-constant lookup.
- done  out  1  one-cycle pulse at the end of a completed sweep.
- last_round  out  1  high together with done when the finished round is NUM_ROUNDS-1.

Behaviour:
- States: IDLE, CLR, LOAD, XOR, DONE. All outputs are Moore, decoded from the state register, except last_round, which is decoded from the state register and the round register.
- Reset (rst=0, asynchronous):
  - state=IDLE, round=0.
  - ready=1, busy=0.
  - cnt_rst_64, inreg_en, xor_en, cnt_en_64, done and last_round are all 0.
  - cnt24_value=0.
- IDLE:
  - ready=1.
  - round_clr=1 sets round to 0 at the next edge.
  - start=1 moves to CLR.
  - If round_clr and start are high in the same cycle, both take effect and the sweep runs on round 0.
- CLR: cnt_rst_64=1 for one cycle, then LOAD.
- LOAD: inreg_en=1 for one cycle, then XOR.
- XOR:
  - xor_en=1 and cnt_en_64=1.
  - If cnt_co_64=1, go to DONE; otherwise return to LOAD.
  - The slice counter therefore steps once per LOAD/XOR pair.
- DONE:
  - done=1 for one cycle.
  - last_round=1 in this cycle iff round=NUM_ROUNDS-1.
  - round increments at the exiting edge and wraps from NUM_ROUNDS-1 to 0.
  - Next state is IDLE.
- Latency:
  - start is sampled at edge k; CLR occupies cycle k+1.
  - LOAD/XOR pairs occupy k+2 through k+129.
  - done is high in cycle k+130.
  - Back-to-back sweeps: the earliest next start is the IDLE cycle following DONE, giving 131 cycles per sweep.
- cnt24_value is stable for the whole sweep; it changes only on the DONE→IDLE edge or on round_clr in IDLE.
- start while busy is ignored; it is not queued.
- round_clr outside IDLE is ignored.
- abort=1 in CLR, LOAD, XOR or DONE:
  - Next state is IDLE.
  - done is not pulsed after an abort in CLR, LOAD or XOR.
  - round is unchanged, including when abort arrives in the DONE cycle, where done is already high.
  - The slice counter is left as-is; the next CLR clears it.
- abort in IDLE has no effect.
- cnt_co_64 is ignored outside XOR.
- Reset asserted mid-sweep returns immediately to the reset values; the partial sweep is discarded.

Decomposition:
- Shared package addrc_pkg holds:
  - NUM_ROUNDS, ROUND_W.
  - State encodings: IDLE=3'd0, CLR=3'd1, LOAD=3'd2, XOR=3'd3, DONE=3'd4. Unused codes recover to IDLE.
- One sub-module, addrc_round_counter:
  - Wrapping modulo-NUM_ROUNDS counter with synchronous clear and increment enable.
  - Asynchronous active-low reset to 0.
  - Outputs the round value and a terminal flag (value = NUM_ROUNDS-1).

Test Plan:
- Reset held low, then released → ready=1, busy=0, cnt24_value=0, all strobes 0.
- Single start pulse with the bench slice counter (carry at 63) → cnt_rst_64 one cycle; exactly 64 inreg_en and 64 xor_en pulses, strictly alternating; done in cycle k+130; cnt24_value 0→1 after done.
- 24 back-to-back sweeps → cnt24_value steps 0..23; last_round coincides with done only on the 24th; the index then wraps to 0.
- abort in the 10th XOR cycle of round 5 → IDLE next cycle, no done, cnt24_value stays 5; a restart completes normally and advances it to 6.
- start pulsed during XOR → ignored: no extra sweep, still 64 XOR pulses.
- round_clr with start in IDLE at round 7 → the sweep runs with cnt24_value=0 and ends at 1.
